// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern overlay: display geometry defaults,
// pattern-mode encodings, box direction encoding and the colour palette.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 1024;
  localparam int BOX_SIZE_DEF = 64;
  localparam int STEP_DEF     = 4;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK   = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_WHITE   = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t RGB_GREY_HI = '{r: 4'h8, g: 4'h8, b: 4'h8};
  localparam rgb_t RGB_GREY_LO = '{r: 4'h4, g: 4'h4, b: 4'h4};

  // Colour-bar lookup: bars 0..7 walk the RGB primaries/secondaries by the
  // bar index bits, bars 8 and 9 are two grey steps filling the last 256 px.
  function automatic rgb_t bar_colour(input logic [3:0] idx);
    rgb_t c;
    c = RGB_BLACK;
    if (idx[3] == 1'b0) begin
      c.r = {4{idx[2]}};
      c.g = {4{idx[1]}};
      c.b = {4{idx[0]}};
    end else if (idx == 4'd8) begin
      c = RGB_GREY_HI;
    end else if (idx == 4'd9) begin
      c = RGB_GREY_LO;
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_box_axis.sv
// One axis of the bouncing box: position plus direction, stepped once per
// frame tick and reflected at 0 and LIMIT so the box never leaves the screen.
module vga_box_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = H_ACTIVE_DEF - BOX_SIZE_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        pause_i,
  output logic [11:0] pos_o
);

  // 12-bit arithmetic leaves headroom above LIMIT + STEP, so no wrap.
  localparam logic [11:0] LIMIT_W = 12'(LIMIT);
  localparam logic [11:0] STEP_W  = 12'(STEP);

  logic [11:0] pos_q, pos_d;
  dir_e        dir_q, dir_d;

  // Next position/direction: clamp to the edge and reverse when the next step would reach it.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick_i && !pause_i) begin
      if (dir_q == DIR_POS) begin
        if (pos_q + STEP_W >= LIMIT_W) begin
          pos_d = LIMIT_W;
          dir_d = DIR_NEG;
        end else begin
          pos_d = pos_q + STEP_W;
        end
      end else begin
        if (pos_q <= STEP_W) begin
          pos_d = '0;
          dir_d = DIR_POS;
        end else begin
          pos_d = pos_q - STEP_W;
        end
      end
    end
  end

  // Axis state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/vga_pattern_overlay.sv
// Pixel-colour stage behind the 1280x1024 timing generator. Decodes the
// selected test pattern in stage 1, applies blanking in stage 2, and delays
// the syncs by the same two cycles so colour and sync reach the pins together.
module vga_pattern_overlay
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode,
  input  logic        pause,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam logic [11:0] BOX_W = 12'(BOX_SIZE);

  logic        frame_tick;
  mode_e       mode_q, mode_d;
  logic [11:0] box_x, box_y;
  logic        in_box;
  rgb_t        colour_d;

  rgb_t        colour_p1_q;
  logic        von_p1_q;
  logic        hs_p1_q, vs_p1_q;

  rgb_t        rgb_p2_q, rgb_p2_d;
  logic        hs_p2_q, vs_p2_q;

  // First blanking line start: once-per-frame update point for mode and box.
  assign frame_tick = (hcount == 11'd0) && (vcount == 11'(V_ACTIVE));

  vga_box_axis #(
    .LIMIT (H_ACTIVE - BOX_SIZE),
    .STEP  (STEP)
  ) u_box_x (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (frame_tick),
    .pause_i (pause),
    .pos_o   (box_x)
  );

  vga_box_axis #(
    .LIMIT (V_ACTIVE - BOX_SIZE),
    .STEP  (STEP)
  ) u_box_y (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (frame_tick),
    .pause_i (pause),
    .pos_o   (box_y)
  );

  // Mode is only latched at the frame boundary so a change never tears the picture.
  always_comb begin
    mode_d = mode_q;
    if (frame_tick) begin
      mode_d = mode_e'(mode);
    end
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_BLACK;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Pattern decode for the pixel currently presented by the timing generator.
  always_comb begin
    in_box = ({1'b0, hcount} >= box_x) && ({1'b0, hcount} < box_x + BOX_W) &&
             ({1'b0, vcount} >= box_y) && ({1'b0, vcount} < box_y + BOX_W);
    colour_d = RGB_BLACK;
    case (mode_q)
      MODE_BLACK: colour_d = RGB_BLACK;
      MODE_BARS:  colour_d = bar_colour(hcount[10:7]);
      MODE_GRID:  colour_d = ((hcount[5:0] == 6'd0) || (vcount[5:0] == 6'd0)) ?
                             RGB_WHITE : RGB_BLACK;
      MODE_BOX:   colour_d = in_box ? RGB_WHITE : bar_colour(hcount[10:7]);
      default:    colour_d = RGB_BLACK;
    endcase
  end

  // ---- stage 1: decoded colour, video_on and syncs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_p1_q <= RGB_BLACK;
      von_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
    end else begin
      colour_p1_q <= colour_d;
      von_p1_q    <= video_on;
      hs_p1_q     <= hsync_in;
      vs_p1_q     <= vsync_in;
    end
  end

  // Blanking overrides every pattern.
  always_comb begin
    rgb_p2_d = von_p1_q ? colour_p1_q : RGB_BLACK;
  end

  // ---- stage 2: output registers driving the VGA pins ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p2_q <= RGB_BLACK;
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
    end else begin
      rgb_p2_q <= rgb_p2_d;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  assign red   = rgb_p2_q.r;
  assign green = rgb_p2_q.g;
  assign blue  = rgb_p2_q.b;
  assign hsync = hs_p2_q;
  assign vsync = vs_p2_q;

endmodule

// File: doc/vga_pattern_overlay.md
Name: vga_pattern_overlay

Overview:
- Pixel-colour stage directly downstream of the 1280x1024 timing generator; consumes its counters, blanking flag and syncs.
- Produces registered 12-bit RGB plus sync delayed to the same alignment, for the board's VGA pins.
- Provides selectable test patterns (black, colour bars, grid, bars with a bouncing box).
- Box position is updated once per frame.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- V_ACTIVE, 1024, visible lines per frame
- BOX_SIZE, 64, box edge length in pixels
- STEP, 4, box displacement per frame per axis, in pixels

Ports:
- clk  in  1  pixel clock, 108 MHz
- rst  in  1  synchronous active-high reset
- hcount  in  11  horizontal pixel counter from the timing generator
- vcount  in  11  vertical line counter from the timing generator
- video_on  in  1  high during the active region
- hsync_in  in  1  horizontal sync from the timing generator
- vsync_in  in  1  vertical sync from the timing generator
- mode  in  2  pattern select
- pause  in  1  freezes box motion
- hsync  out  1  hsync_in delayed 2 cycles
- vsync  out  1  vsync_in delayed 2 cycles
- red  out  4  red channel
- green  out  4  green channel
- blue  out  4  blue channel

Behaviour:
- Single clock, clk; rst is synchronous and active-high.
- Reset values:
  - red/green/blue = 0, hsync = 0, vsync = 0; both sync pipeline stages cleared.
  - box_x = 0, box_y = 0, dir_x = +, dir_y = +.
  - mode_q = 0.
- Pipeline: 2-cycle latency.
  - Stage 1 registers the pattern decode and the delayed video_on.
  - Stage 2 registers the RGB outputs.
  - hsync/vsync pass through an identical 2-stage shift, so pixel N's colour and sync leave together.
- Blanking: if video_on delayed to stage 2 is 0, RGB = 0 regardless of mode.
- frame_tick is a one-cycle pulse when hcount == 0 && vcount == V_ACTIVE (first blank line).
- mode is sampled into mode_q only on frame_tick, so a mid-frame change never tears the picture.
- mode_q 0: black.
- mode_q 1, colour bars:
  - idx = hcount[10:7], giving 0..9.
  - For idx 0..7: R = {4{idx[2]}}, G = {4{idx[1]}}, B = {4{idx[0]}}.
  - idx 8: all channels 4'h8. idx 9: all channels 4'h4.
- mode_q 2, grid: white (F,F,F) when hcount[5:0] == 0 or vcount[5:0] == 0, else black.
- mode_q 3, bars with box:
  - White when box_x <= hcount < box_x+BOX_SIZE and box_y <= vcount < box_y+BOX_SIZE.
  - Otherwise the mode 1 colour.
- Box motion: on frame_tick with pause == 0, each axis updates independently (X shown; Y is identical using V_ACTIVE).
  - dir +: if box_x + STEP >= H_ACTIVE - BOX_SIZE, then box_x = H_ACTIVE - BOX_SIZE and dir flips to -. Else box_x += STEP.
  - dir -: if box_x <= STEP, then box_x = 0 and dir flips to +. Else box_x -= STEP.
  - Arithmetic is 12-bit internally to avoid wrap; the box is never partially off-screen.
  - Corner hit: both axes flip in the same tick.
- pause == 1 on frame_tick: position and direction are held; patterns still render.
- rst asserted mid-frame: the next cycle shows outputs at reset values; rendering resumes with valid alignment 2 cycles after rst deasserts.
- Counter values outside the active region are ignored; blanking takes precedence.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults for 1280x1024.
  - Mode encodings MODE_BLACK = 0, MODE_BARS = 1, MODE_GRID = 2, MODE_BOX = 3.
  - The colour constants.
- Sub-module vga_box_axis: one bouncing axis (position and direction registers, tick, pause, LIMIT = ACTIVE - BOX_SIZE, STEP).
  - Instantiated twice, once for X and once for Y.

Test Plan:
- Reset then release, mode 1, hcount sweep at vcount = 10: hcount 0 -> RGB 000 two cycles later; hcount 128 -> 00F; hcount 896 -> FFF; hcount 1024 -> 888; hcount 1152 -> 444.
- Sync alignment: hsync_in pulse at cycle T -> hsync pulse at T+2, same cycle as the colour of the pixel presented at T; video_on = 0 pixels -> RGB 000.
- Mode 2: hcount 64, vcount 5 -> FFF; hcount 65, vcount 5 -> 000; hcount 65, vcount 128 -> FFF.
- Box bounce: mode 3, drive 304 frame_ticks -> box_x = 1216 with dir_x flipped to -; next tick -> box_x = 1212; box_y reaches 960 at tick 240 and flips.
- Mode change at vcount = 500 -> output pattern unchanged until the frame_tick at vcount 1024; pause = 1 across 5 ticks -> box_x/box_y constant.
- rst pulse mid-line -> RGB, hsync, vsync = 0 the next cycle; box returns to (0,0, +,+).
